// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and latency constants for the pipeline hazard controller.
// The mult/div unit imports the same latency constants.
package pipe_hazard_ctrl_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // en/clr bit order is {FD, DE, EM, MW}
  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] clr;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_IDLE = '{
    pc_en: 1'b1,
    en:    4'b1111,
    clr:   4'b0000
  };

  localparam int FD = 3;
  localparam int DE = 2;
  localparam int EM = 1;
  localparam int MW = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// Mult/div busy tracker: 2-state FSM plus down-counter.
// Ports: clk, reset (async, active-low), md_start_E, md_is_div_E, exc_taken_M -> md_busy.
module md_busy_tracker
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_E,
  input  logic md_is_div_E,
  input  logic exc_taken_M,
  output logic md_busy
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] md_cnt, cnt_d;
  logic             issue;

  // An exception in the issue cycle cancels the mult/div.
  assign issue = md_start_E & ~exc_taken_M;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      md_cnt  <= '0;
    end else begin
      state_q <= state_d;
      md_cnt  <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = md_cnt;
    unique case (state_q)
      MD_IDLE: begin
        if (issue) begin
          state_d = MD_BUSY;
          cnt_d   = md_is_div_E ?
                    CNT_W'(DIV_CYCLES - 1) :
                    CNT_W'(MULT_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        if (md_cnt == '0)
          state_d = MD_IDLE;
        else
          cnt_d = md_cnt - 1'b1;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_busy = (state_q == MD_BUSY) | issue;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register en/clr and PC enable: exception flush > stall > eret.
// Optional PIPE_HAZARD_STAT_EN adds stall_cycles/flush_count counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hz_stall_D,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        md_use_D,
  input  logic        exc_taken_M,
  input  logic        eret_D,
  output logic        pc_en,
  output logic        en_FD,
  output logic        en_DE,
  output logic        en_EM,
  output logic        en_MW,
  output logic        clr_FD,
  output logic        clr_DE,
  output logic        clr_EM,
  output logic        clr_MW,
  output logic        md_busy
`ifdef PIPE_HAZARD_STAT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  pipe_ctl_t ctl;
  logic      stall;
  logic      sel_exc;
  logic      sel_stall;
  logic      sel_eret;

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md (
    .clk         (clk),
    .reset       (reset),
    .md_start_E  (md_start_E),
    .md_is_div_E (md_is_div_E),
    .exc_taken_M (exc_taken_M),
    .md_busy     (md_busy)
  );

  assign stall = hz_stall_D | (md_use_D & md_busy);

  // Disjoint selects encode the priority order.
  assign sel_exc   = exc_taken_M;
  assign sel_stall = ~exc_taken_M & stall;
  assign sel_eret  = ~exc_taken_M & ~stall & eret_D;

  always_comb begin
    ctl = CTL_IDLE;
    unique case (1'b1)
      sel_exc: begin
        ctl.clr = 4'b1111;
      end
      sel_stall: begin
        ctl.pc_en   = 1'b0;
        ctl.en[FD]  = 1'b0;
        ctl.clr[DE] = 1'b1;
      end
      sel_eret: begin
        ctl.clr[FD] = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_en  = ctl.pc_en;
  assign en_FD  = ctl.en[FD];
  assign en_DE  = ctl.en[DE];
  assign en_EM  = ctl.en[EM];
  assign en_MW  = ctl.en[MW];
  assign clr_FD = ctl.clr[FD];
  assign clr_DE = ctl.clr[DE];
  assign clr_EM = ctl.clr[EM];
  assign clr_MW = ctl.clr[MW];

`ifdef PIPE_HAZARD_STAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (sel_stall)
        stall_cycles <= stall_cycles + 32'd1;
      if (sel_exc)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// Directed scenarios plus random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hz_stall_D = 0, md_start_E = 0, md_is_div_E = 0;
  logic md_use_D = 0, exc_taken_M = 0, eret_D = 0;
  logic pc_en, en_FD, en_DE, en_EM, en_MW;
  logic clr_FD, clr_DE, clr_EM, clr_MW, md_busy;
`ifdef PIPE_HAZARD_STAT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipe_hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .hz_stall_D  (hz_stall_D),
    .md_start_E  (md_start_E),
    .md_is_div_E (md_is_div_E),
    .md_use_D    (md_use_D),
    .exc_taken_M (exc_taken_M),
    .eret_D      (eret_D),
    .pc_en       (pc_en),
    .en_FD       (en_FD),
    .en_DE       (en_DE),
    .en_EM       (en_EM),
    .en_MW       (en_MW),
    .clr_FD      (clr_FD),
    .clr_DE      (clr_DE),
    .clr_EM      (clr_EM),
    .clr_MW      (clr_MW),
    .md_busy     (md_busy)
`ifdef PIPE_HAZARD_STAT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: cycles of busy still owed after the current one.
  int busy_left = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  logic [9:0] obs;
  int cnt_busy, cnt_pcoff;

  localparam logic [9:0] IDLE_V = 10'b1_1111_0000_0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
  endtask

  // Vector: {pc_en, en FD DE EM MW, clr FD DE EM MW, md_busy}
  function automatic logic [9:0] model(input logic hz, st, use_, ex, er);
    bit busy, stl;
    logic [9:0] v;
    busy = (busy_left > 0) || (st && !ex);
    stl = hz || (use_ && busy);
    v = IDLE_V;
    v[0] = busy;
    if (ex)
      v[4:1] = 4'b1111;
    else if (stl) begin
      v[9] = 1'b0;
      v[8] = 1'b0;
      v[3] = 1'b1;
    end else if (er)
      v[4] = 1'b1;
    return v;
  endfunction

  function automatic logic [9:0] sample();
    return {pc_en, en_FD, en_DE, en_EM, en_MW,
            clr_FD, clr_DE, clr_EM, clr_MW, md_busy};
  endfunction

  task automatic step(input logic hz, st, dv, use_, ex, er);
    logic [9:0] e;
    bit stl;
    hz_stall_D = hz;
    md_start_E = st;
    md_is_div_E = dv;
    md_use_D = use_;
    exc_taken_M = ex;
    eret_D = er;
    e = model(hz, st, use_, ex, er);
    stl = hz || (use_ && e[0]);
    @(negedge clk);
    obs = sample();
    chk("outs", {22'd0, obs}, {22'd0, e});
`ifdef PIPE_HAZARD_STAT_EN
    chk("stall_cycles", stall_cycles, m_stall[31:0]);
    chk("flush_count", flush_count, m_flush[31:0]);
`endif
    if (obs[0]) cnt_busy++;
    if (!obs[9]) cnt_pcoff++;
    @(posedge clk);
    if (!reset) begin
      busy_left = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (stl && !ex) m_stall++;
      if (ex) m_flush++;
      if (busy_left > 0)
        busy_left--;
      else if (st && !ex)
        busy_left = dv ? 10 : 5;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    idle(3);
    reset = 1'b1;
    idle(3);

    // mult with dependent D-stage instruction
    cnt_busy = 0; cnt_pcoff = 0;
    step(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 1, 0, 0);
    chk("mult_busy_len", cnt_busy, 6);
    chk("mult_stall_len", cnt_pcoff, 6);
    chk("mult_pc_resume", {31'd0, obs[9]}, 1);
    idle(1);

    // div
    cnt_busy = 0; cnt_pcoff = 0;
    step(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 11; i++)
      step(0, 0, 0, 1, 0, 0);
    chk("div_busy_len", cnt_busy, 11);
    chk("div_stall_len", cnt_pcoff, 11);
    idle(1);

    // exception during div does not cancel it
    cnt_busy = 0;
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("exc_flush", {22'd0, obs}, {22'd0, 10'b1_1111_1111_1});
    for (int i = 0; i < 9; i++)
      step(0, 0, 0, 0, 0, 0);
    chk("exc_div_len", cnt_busy, 11);

    // start cancelled by simultaneous exception
    step(0, 1, 1, 0, 1, 0);
    chk("cancel_busy", {31'd0, obs[0]}, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("cancel_next", {31'd0, obs[0]}, 0);

    // stall beats eret, then eret alone
    step(1, 0, 0, 0, 0, 1);
    chk("stall_eret", {22'd0, obs}, {22'd0, 10'b0_0111_0100_0});
    step(0, 0, 0, 0, 0, 1);
    chk("eret_only", {22'd0, obs}, {22'd0, 10'b1_1111_1000_0});

    // async reset in busy cycle 3 of a div
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    {hz_stall_D, md_start_E, md_is_div_E} = 3'b000;
    {md_use_D, exc_taken_M, eret_D} = 3'b000;
    reset = 1'b0;
    busy_left = 0;
    m_stall = 0;
    m_flush = 0;
    #1;
    chk("rst_async", {22'd0, sample()}, {22'd0, IDLE_V});
    @(negedge clk);
    chk("rst_hold", {31'd0, md_busy}, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cnt_busy = 0;
    step(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 1, 0, 0);
    chk("post_rst_mult", cnt_busy, 6);

    // random traffic; never issue while the unit is busy
    for (int i = 0; i < 400; i++) begin
      logic st;
      st = (busy_left == 0) && ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 4) == 0, st, 1'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control end of the pipeline-register interface. Generates the `en`/`clr` pair for each of the four 32-bit pipeline registers (F/D, D/E, E/M, M/W), plus the PC write enable.
- Merges three sources: load-use hazard stall, multi-cycle mult/div busy tracking, and exception/interrupt/eret flush.
- Sits beside the hazard-detection logic in the P7 core. Feeds every pipeline register stage and the PC.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu issue.
- DIV_CYCLES, 10, busy cycles after div/divu issue.
- CNT_W, 4, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- hz_stall_D  in  1  combinational load-use/forwarding stall request from decode.
- md_start_E  in  1  mult/div instruction in E this cycle.
- md_is_div_E  in  1  1 = div/divu, 0 = mult/multu; valid with md_start_E.
- md_use_D  in  1  D-stage instruction touches HI/LO or the mult/div unit.
- exc_taken_M  in  1  exception/interrupt accepted at M (from CP0).
- eret_D  in  1  eret in D.
- pc_en  out  1  PC write enable.
- en_FD, en_DE, en_EM, en_MW  out  1 each  pipeline register enables.
- clr_FD, clr_DE, clr_EM, clr_MW  out  1 each  synchronous clears, with priority over en.
- md_busy  out  1  mult/div unit busy.

Behaviour:
- Sequential state is a CNT_W-bit counter `md_cnt` and a 2-state FSM (IDLE, BUSY). Reset sets state to IDLE and md_cnt to 0. All other outputs are combinational from inputs and state.
- Reset and idle output values: pc_en=1, all en_*=1, all clr_*=0, md_busy=0.
- IDLE -> BUSY:
  - Condition: md_start_E=1 and exc_taken_M=0.
  - md_cnt loads DIV_CYCLES-1 if md_is_div_E, else MULT_CYCLES-1.
- BUSY:
  - md_cnt decrements each cycle.
  - When md_cnt==0 on a clock edge, go to IDLE.
  - Total busy window is exactly MULT_CYCLES or DIV_CYCLES cycles after the issue cycle.
- md_start_E while in BUSY is ignored. The stall below prevents it; the bench asserts it never occurs.
- md_busy = (state==BUSY) | (md_start_E & ~exc_taken_M).
- stall = hz_stall_D | (md_use_D & md_busy).
- Output priority, highest first:
  1. exc_taken_M=1:
     - clr_FD = clr_DE = clr_EM = clr_MW = 1.
     - All en_* = 1, pc_en = 1 (PC loads the handler address).
     - Stall and eret are ignored.
     - A running mult/div is not cancelled (HI/LO update still completes).
     - md_start_E in the same cycle is cancelled and no load occurs.
  2. stall=1:
     - pc_en = 0, en_FD = 0.
     - clr_DE = 1 (bubble into E).
     - en_DE = en_EM = en_MW = 1.
     - Other clr_* = 0.
  3. eret_D=1 with no stall: clr_FD = 1 (kills the instruction fetched after eret). Everything else stays at idle values.
  4. Otherwise: idle values.
- Asynchronous reset mid-BUSY: state returns to IDLE and md_cnt to 0 immediately. Outputs revert to idle values in the same cycle.
- No combinational path from an output back to any input.

Optional Feature:
- Macro: PIPE_HAZARD_STAT_EN.
- Defined:
  - Adds output ports stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments each cycle stall=1 and exc_taken_M=0.
  - flush_count increments each cycle exc_taken_M=1.
  - Both wrap at 2^32. Both are cleared by reset.
- Not defined: ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package (or include):
  - state encodings MD_IDLE=1'b0, MD_BUSY=1'b1;
  - default MULT_CYCLES/DIV_CYCLES constants, also used by the mult/div unit so both agree on latency.
- One natural sub-module, md_busy_tracker: the FSM plus counter. Inputs clk, reset, md_start_E, md_is_div_E, exc_taken_M; output md_busy.
- The top level holds only the priority mux.

Test Plan:
- Reset low 3 cycles, then high with all inputs 0 -> pc_en=1, en_*=1, clr_*=0, md_busy=0 throughout.
- md_start_E=1, md_is_div_E=0 for 1 cycle, then md_use_D=1 held:
  - md_busy=1 for 6 cycles (issue + 5), pc_en=0 and clr_DE=1 in each.
  - pc_en returns to 1 on cycle 7.
  - Repeat with div: 11 cycles.
- Div issued, exc_taken_M=1 on the 4th busy cycle -> all clr_*=1, pc_en=1 that cycle; md_busy remains 1 until the 11th cycle.
- md_start_E=1 and exc_taken_M=1 in the same cycle -> md_busy=0 the next cycle; counter not loaded.
- hz_stall_D=1 and eret_D=1 together -> pc_en=0, en_FD=0, clr_DE=1, clr_FD=0; next cycle with hz_stall_D=0 and eret_D=1 -> clr_FD=1, pc_en=1.
- Reset pulsed low mid-div (busy cycle 3) -> md_busy=0 immediately and after release; a new mult issue then gives a correct 6-cycle busy window.
